// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage MIPS pipeline sequencer.
package pipe_pkg;

    localparam int unsigned PIPE_REG_W = 5;
    localparam int unsigned ZERO_REG   = 0;

    typedef enum logic {
        StRun   = 1'b0,
        StDwait = 1'b1
    } state_e;

    // Enumerated in arbitration order; the DWAIT-only sources come last.
    typedef enum logic [2:0] {
        SrcNone    = 3'd0,
        SrcDmem    = 3'd1,
        SrcBranch  = 3'd2,
        SrcLoadUse = 3'd3,
        SrcJump    = 3'd4,
        SrcImem    = 3'd5,
        SrcDwait   = 3'd6,
        SrcTimeout = 3'd7
    } stall_src_e;

endpackage

// File: rtl/pipe_dwait_timer.sv
// Saturating data-memory wait counter with clear, increment and terminal count.
module pipe_dwait_timer #(
    parameter int unsigned MAX = 15,
    parameter int unsigned CW  = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [CW-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CW'(MAX))) begin
            count_d = count_q + 1'b1;
        end
    end

    assign tc = (count_q == CW'(MAX));

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer: stall arbitration and pipeline-register controls.
// Optional statistics counters are built when PIPE_STALL_STATS_EN is defined.
module pipe_seq_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_W     = PIPE_REG_W,
    parameter int unsigned DWAIT_MAX = 15,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             ex_mem_bubble,
    output logic             mem_wb_write,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    state_e     state_q, state_d;
    stall_src_e stall_src;
    logic       bus_err_q, bus_err_d;
    logic       cnt_clr, cnt_inc, cnt_tc;
    logic       load_use;

    pipe_dwait_timer #(
        .MAX (DWAIT_MAX)
    ) u_dwait_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .tc    (cnt_tc)
    );

    assign load_use = id_ex_mem_read && (id_ex_rd != REG_W'(ZERO_REG)) &&
                      ((id_ex_rd == if_id_rs) || (id_ex_rd == if_id_rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        stall_src = SrcNone;
        if (state_q == StRun) begin
            if (dmem_req && !dmem_ready) begin
                stall_src = SrcDmem;
            end else if (branch_taken) begin
                stall_src = SrcBranch;
            end else if (load_use) begin
                stall_src = SrcLoadUse;
            end else if (jump) begin
                stall_src = SrcJump;
            end else if (!imem_ready) begin
                stall_src = SrcImem;
            end
        end else if (dmem_req && !dmem_ready) begin
            // A dropped request is treated as completion, so only a live wait gets here.
            stall_src = cnt_tc ? SrcTimeout : SrcDwait;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        bus_err_d = 1'b0;
        unique case (stall_src)
            SrcDmem, SrcDwait: begin
                state_d = StDwait;
                cnt_inc = 1'b1;
            end
            SrcTimeout: begin
                state_d   = StRun;
                cnt_clr   = 1'b1;
                bus_err_d = 1'b1;
            end
            default: begin
                state_d = StRun;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_write  = 1'b1;
        ex_mem_bubble = 1'b0;
        mem_wb_write  = 1'b1;
        unique case (stall_src)
            SrcDmem, SrcDwait: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
                mem_wb_write = 1'b0;
            end
            SrcBranch: begin
                if_id_flush   = 1'b1;
                id_ex_bubble  = 1'b1;
                ex_mem_bubble = 1'b1;
            end
            SrcLoadUse: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
            SrcJump: if_id_flush = 1'b1;
            SrcImem: begin
                pc_write    = 1'b0;
                if_id_flush = 1'b1;
            end
            SrcTimeout: ex_mem_bubble = 1'b1;
            default: ;
        endcase
        if (!rst_n) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_write   = 1'b0;
            id_ex_bubble  = 1'b0;
            ex_mem_write  = 1'b0;
            ex_mem_bubble = 1'b0;
            mem_wb_write  = 1'b0;
        end
    end

    assign bus_err = bus_err_q;

`ifdef PIPE_STALL_STATS_EN
    logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_write) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
            if (if_id_flush) begin
                flush_count_q <= flush_count_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed self-checking bench for pipe_seq_ctrl (default DWAIT_MAX=15).
module tb_pipe_seq_ctrl;

    localparam logic [7:0] O_ZERO  = 8'h00;
    localparam logic [7:0] O_DEF   = 8'hD5;
    localparam logic [7:0] O_FRZ   = 8'h00;
    localparam logic [7:0] O_BR    = 8'hFF;
    localparam logic [7:0] O_LU    = 8'h1D;
    localparam logic [7:0] O_JMP   = 8'hF5;
    localparam logic [7:0] O_IMEM  = 8'h75;
    localparam logic [7:0] O_TMO   = 8'hD7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  if_id_rs, if_id_rt, id_ex_rd;
    logic        id_ex_mem_read, branch_taken, jump, imem_ready, dmem_req, dmem_ready;
    logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
    logic        ex_mem_write, ex_mem_bubble, mem_wb_write, bus_err;
    logic [31:0] stall_cycles, flush_count;
    logic [7:0]  outs;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
                   ex_mem_write, ex_mem_bubble, mem_wb_write};

    pipe_seq_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rd       (id_ex_rd),
        .branch_taken   (branch_taken),
        .jump           (jump),
        .imem_ready     (imem_ready),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_write    (id_ex_write),
        .id_ex_bubble   (id_ex_bubble),
        .ex_mem_write   (ex_mem_write),
        .ex_mem_bubble  (ex_mem_bubble),
        .mem_wb_write   (mem_wb_write),
        .bus_err        (bus_err),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    task automatic idle();
        if_id_rs       = 5'd0;
        if_id_rt       = 5'd0;
        id_ex_rd       = 5'd0;
        id_ex_mem_read = 1'b0;
        branch_taken   = 1'b0;
        jump           = 1'b0;
        imem_ready     = 1'b1;
        dmem_req       = 1'b0;
        dmem_ready     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #1;
        checks++;
        if (outs !== O_ZERO || bus_err !== 1'b0) begin
            $display("FAIL reset_outputs outs=%h bus_err=%b want outs=%h bus_err=0",
                     outs, bus_err, O_ZERO);
        end else passes++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs !== O_DEF || bus_err !== 1'b0) begin
            $display("FAIL reset_defaults outs=%h bus_err=%b want outs=%h bus_err=0",
                     outs, bus_err, O_DEF);
        end else passes++;
    endtask

    task automatic test_load_use();
        @(negedge clk);
        idle();
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd8; if_id_rt = 5'd8; if_id_rs = 5'd3;
        #1;
        checks++;
        if (outs !== O_LU) $display("FAIL load_use_rt outs=%h want=%h", outs, O_LU);
        else passes++;
        // The bubble has cleared mem_read in EX on the following cycle.
        @(negedge clk);
        id_ex_mem_read = 1'b0;
        #1;
        checks++;
        if (outs !== O_DEF) $display("FAIL load_use_release outs=%h want=%h", outs, O_DEF);
        else passes++;
        @(negedge clk);
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd0; if_id_rt = 5'd0; if_id_rs = 5'd0;
        #1;
        checks++;
        if (outs !== O_DEF) $display("FAIL load_use_r0 outs=%h want=%h", outs, O_DEF);
        else passes++;
        @(negedge clk);
        id_ex_rd = 5'd12; if_id_rs = 5'd12; if_id_rt = 5'd1;
        #1;
        checks++;
        if (outs !== O_LU) $display("FAIL load_use_rs outs=%h want=%h", outs, O_LU);
        else passes++;
        @(negedge clk);
        idle();
    endtask

    task automatic test_dmem_wait();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle();
            dmem_req     = 1'b1;
            branch_taken = (i == 1);
            #1;
            checks++;
            if (outs !== O_FRZ || bus_err !== 1'b0) begin
                $display("FAIL dmem_freeze[%0d] outs=%h bus_err=%b want outs=%h bus_err=0",
                         i, outs, bus_err, O_FRZ);
            end else passes++;
        end
        @(negedge clk);
        idle();
        dmem_req = 1'b1; dmem_ready = 1'b1;
        #1;
        checks++;
        if (outs !== O_DEF) $display("FAIL dmem_complete outs=%h want=%h", outs, O_DEF);
        else passes++;
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (outs !== O_DEF || bus_err !== 1'b0) begin
            $display("FAIL dmem_after outs=%h bus_err=%b want outs=%h bus_err=0",
                     outs, bus_err, O_DEF);
        end else passes++;
    endtask

    task automatic test_timeout();
        int bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            idle();
            dmem_req = 1'b1;
            #1;
            if (outs !== O_FRZ || bus_err !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL timeout_freeze bad_cycles=%0d want=0", bad);
        else passes++;
        @(negedge clk);
        #1;
        checks++;
        if (outs !== O_TMO || bus_err !== 1'b0) begin
            $display("FAIL timeout_cycle outs=%h bus_err=%b want outs=%h bus_err=0",
                     outs, bus_err, O_TMO);
        end else passes++;
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (outs !== O_DEF || bus_err !== 1'b1) begin
            $display("FAIL timeout_err outs=%h bus_err=%b want outs=%h bus_err=1",
                     outs, bus_err, O_DEF);
        end else passes++;
        @(negedge clk);
        #1;
        checks++;
        if (bus_err !== 1'b0) $display("FAIL timeout_pulse bus_err=%b want=0", bus_err);
        else passes++;
    endtask

    task automatic test_branch_priority();
        @(negedge clk);
        idle();
        branch_taken = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = 5'd8; if_id_rt = 5'd8;
        #1;
        checks++;
        if (outs !== O_BR) $display("FAIL branch_over_lu outs=%h want=%h", outs, O_BR);
        else passes++;
        @(negedge clk);
        dmem_req = 1'b1;
        #1;
        checks++;
        if (outs !== O_FRZ) $display("FAIL dmem_over_branch outs=%h want=%h", outs, O_FRZ);
        else passes++;
        @(negedge clk);
        idle();
        dmem_req = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b1;
        #1;
        checks++;
        if (outs !== O_DEF) $display("FAIL dwait_ignore_branch outs=%h want=%h", outs, O_DEF);
        else passes++;
        @(negedge clk);
        idle();
    endtask

    task automatic test_jump_imem();
        @(negedge clk);
        idle();
        jump = 1'b1; imem_ready = 1'b0;
        #1;
        checks++;
        if (outs !== O_JMP) $display("FAIL jump_over_imem outs=%h want=%h", outs, O_JMP);
        else passes++;
        @(negedge clk);
        jump = 1'b0;
        #1;
        checks++;
        if (outs !== O_IMEM) $display("FAIL imem_wait outs=%h want=%h", outs, O_IMEM);
        else passes++;
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_mid_dwait();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle();
            dmem_req = 1'b1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== O_ZERO || bus_err !== 1'b0) begin
            $display("FAIL reset_mid_dwait outs=%h bus_err=%b want outs=%h bus_err=0",
                     outs, bus_err, O_ZERO);
        end else passes++;
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs !== O_DEF || stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            $display("FAIL reset_release outs=%h stall=%0d flush=%0d want outs=%h stall=0 flush=0",
                     outs, stall_cycles, flush_count, O_DEF);
        end else passes++;
        @(negedge clk);
        #1;
        checks++;
        if (bus_err !== 1'b0 || outs !== O_DEF) begin
            $display("FAIL reset_no_err outs=%h bus_err=%b want outs=%h bus_err=0",
                     outs, bus_err, O_DEF);
        end else passes++;
`ifdef PIPE_STALL_STATS_EN
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        imem_ready = 1'b1;
        #1;
        checks++;
        if (stall_cycles !== 32'd1 || flush_count !== 32'd1) begin
            $display("FAIL stats_count stall=%0d flush=%0d want stall=1 flush=1",
                     stall_cycles, flush_count);
        end else passes++;
`endif
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_dmem_wait();
        test_timeout();
        test_branch_priority();
        test_jump_imem();
        test_reset_mid_dwait();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_seq_ctrl.md
Name: pipe_seq_ctrl

Overview:
Registered pipeline sequencer for the 5-stage MIPS core. It generates all pipeline-register enables, flushes and bubbles.
- Arbitrates four stall sources in fixed priority: data-memory wait, taken-branch flush, load-use, and jump / instruction-fetch wait.
- Adds a bounded wait state for variable-latency data memory, with a timeout error.
- Sits beside the IF/ID/EX/MEM/WB registers and drives their write/flush/bubble controls.

Parameters:
REG_W, 5, register-specifier width
DWAIT_MAX, 15, max consecutive cycles a data access may wait before timeout (>=1)
CNT_W, 32, width of statistics counters (optional feature)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
if_id_rs  in  REG_W  rs of instruction in ID
if_id_rt  in  REG_W  rt of instruction in ID
id_ex_mem_read  in  1  instruction in EX is a load
id_ex_rd  in  REG_W  destination of instruction in EX
branch_taken  in  1  branch in EX resolved taken
jump  in  1  jump decoded in ID
imem_ready  in  1  fetch data valid this cycle
dmem_req  in  1  MEM stage issuing a data access
dmem_ready  in  1  data access completes this cycle
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID cleared to NOP
id_ex_write  out  1  ID/EX load enable
id_ex_bubble  out  1  ID/EX loads NOP
ex_mem_write  out  1  EX/MEM load enable
ex_mem_bubble  out  1  EX/MEM loads NOP
mem_wb_write  out  1  MEM/WB load enable
bus_err  out  1  one-cycle pulse on data-access timeout
stall_cycles  out  CNT_W  statistics (optional)
flush_count  out  CNT_W  statistics (optional)

Behaviour:
- Reset and default outputs:
  - One clock domain; rst_n asynchronous active-low.
  - While rst_n=0, all outputs are 0, state=RUN, and the wait counter is 0.
  - After reset, default outputs: every *_write=1, every flush/bubble=0, bus_err=0.
- States: RUN, DWAIT. Outputs are combinational from state and inputs; state, counter and bus_err are registered.
- RUN, priority high to low:
  1. dmem_req=1 and dmem_ready=0:
     - pc_write, if_id_write, id_ex_write, ex_mem_write and mem_wb_write all =0 (full freeze).
     - Next state DWAIT, counter <= 1.
  2. branch_taken=1:
     - if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1; pc_write=1.
  3. Load-use: id_ex_mem_read=1, id_ex_rd!=0, and (id_ex_rd==if_id_rs or id_ex_rd==if_id_rt):
     - pc_write=0, if_id_write=0, id_ex_bubble=1.
     - The bubble clears id_ex_mem_read next cycle, so the stall lasts exactly 1 cycle.
  4. jump=1: if_id_flush=1.
  5. imem_ready=0: pc_write=0, if_id_flush=1 (bubble into ID; older stages advance).
  6. Otherwise: defaults.
  - Cases 4 and 5 together: jump wins; PC still writes the target.
- DWAIT:
  - Full freeze (as case 1) while dmem_ready=0 and counter<DWAIT_MAX; counter increments by 1 per cycle (saturating width clog2(DWAIT_MAX+1)).
  - dmem_ready=1: defaults this cycle (access completes, pipeline advances); next state RUN, counter <= 0.
  - Counter==DWAIT_MAX with dmem_ready=0:
    - ex_mem_bubble=1, mem_wb_write=1, all other enables 1.
    - bus_err <= 1 for one cycle; next state RUN.
  - branch_taken, jump, load-use and imem_ready are ignored in DWAIT. Their stages are frozen, so they are re-evaluated in RUN.
- dmem_req dropping while in DWAIT is treated as ready (return to RUN, no error).
- Reset mid-DWAIT: immediate return to RUN with outputs 0; no bus_err.

Optional Feature:
- Macro PIPE_STALL_STATS_EN.
- Defined:
  - stall_cycles increments every cycle in which pc_write=0 after reset.
  - flush_count increments every cycle in which if_id_flush=1.
  - Both wrap at 2^CNT_W and reset to 0.
- Undefined: both ports present and tied to 0; no counter flops.

Decomposition:
- Shared package pipe_pkg:
  - state enum (RUN=0, DWAIT=1).
  - REG_W and zero-register constant.
  - Stall-source priority encoding used by debug.
- One natural sub-module, pipe_dwait_timer: saturating wait counter with clear, increment and terminal-count output.

Test Plan:
1. id_ex_mem_read=1, id_ex_rd=8, if_id_rt=8 -> exactly 1 cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; same with id_ex_rd=0 -> no stall.
2. dmem_req=1, dmem_ready low for 3 cycles then high -> 3 cycles of all enables=0, 4th cycle defaults, bus_err never set.
3. dmem_ready held low with DWAIT_MAX=15 -> freeze for 15 cycles, then ex_mem_bubble=1 and bus_err=1 for 1 cycle, then RUN.
4. branch_taken=1 with a load-use match in the same cycle -> if_id_flush=id_ex_bubble=ex_mem_bubble=1, pc_write=1 (branch wins).
5. jump=1 with imem_ready=0 -> if_id_flush=1, pc_write=1; next cycle imem_ready=0 alone -> pc_write=0, if_id_flush=1.
6. rst_n deasserted mid-DWAIT -> all outputs 0 immediately; after release, defaults and no bus_err. With PIPE_STALL_STATS_EN, counters read 0.
